wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the pipelined CPU: consumes the MEM/WB pipeline register outputs, selects the write-back value, and owns the architectural state written at the end of the pipe. That state is the 32×32 general register file with decode-stage read ports, and a minimal CP0 (Count, Compare, Status, Cause, EPC) with a timer interrupt and exception entry/return. It sits after the MEM/WB register and feeds ID (register reads), the hazard/IF logic (irq, epc).

## Interface
- No parameters; widths and encodings come from the shared definitions file.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- read_mem_data_in, alu_result_in, ext_imm_in, re_addr_in  in  32 each  MEM/WB data
- dst_reg_in  in  5  GPR destination
- reg_write_in, cp0_write_in  in  1 each  write enables from MEM/WB
- reg_src_in  in  `REG_SRC_LENGTH` (3)  write-back source select
- rs_addr, rt_addr  in  5 each  ID read addresses; rs_data, rt_data  out  32 each
- exc_req  in  1  take exception this cycle; exc_code  in  5; exc_pc  in  32
- eret  in  1  exception return
- epc  out  32  current EPC; irq  out  1  pending enabled interrupt
- wb_data  out  32  selected write-back value (for forwarding)

## Operation
- wb_data select: ALU→alu_result_in, MEM→read_mem_data_in, IMM→ext_imm_in, RA→re_addr_in, CP0→CP0[ext_imm_in[15:11]]; any other code→0.
- GPR write: if reg_write_in and dst_reg_in≠0, reg[dst_reg_in]←wb_data. reg[0] reads 0 always.
- GPR read: combinational; if reg_write_in, dst_reg_in≠0 and address matches, returns wb_data (write-through bypass).
- CP0 index = ext_imm_in[15:11] for mtc0 and mfc0; mtc0 data = alu_result_in. Indices: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; other indices read 0, writes ignored.
- Status: bit0 IE, bit1 EXL, bits15:8 IM; other bits read 0. Cause: bits15:8 IP (only IP7=bit15 live, set by timer), bits6:2 ExcCode; others 0.
- Count increments by 1 every cycle, wraps 0xFFFFFFFF→0.
- Timer: when Count==Compare and Compare≠0, IP7←1 next edge; any mtc0 to Compare clears IP7.
- exc_req: EPC←exc_pc, Cause.ExcCode←exc_code, Status.EXL←1.
- eret: Status.EXL←0.
- irq = IE & ~EXL & |(IP & IM), combinational from registered state.
- Priorities (same cycle):
  - exc_req > eret.
  - exc_req > mtc0 to Status/Cause/EPC (write dropped); mtc0 to Count/Compare still proceeds.
  - mtc0 Count > increment.
  - mtc0 Compare > timer set (IP7 ends 0).
  - eret with mtc0 Status: mtc0 value applied, then EXL forced 0.

## Timing
- Reset (rst low, async): all GPRs 0, all CP0 registers 0, so irq=0, epc=0; wb_data/rs_data/rt_data follow combinationally from reset state and inputs.
- Reset mid-operation clears state immediately; the first post-reset edge has Count go 0→1.
- GPR and CP0 writes: visible in state after the rising edge; GPR value visible to ID reads in the same cycle via bypass.
- mfc0 reads pre-edge CP0 values. Count read at cycle N returns the value before that edge's increment.
- Timer match at edge E (compare evaluated on pre-edge Count) → IP7 set after E → irq high after E if enabled.

## Structure
- Shared definitions file: REG_SRC_* codes (ALU=0, MEM=1, IMM=2, RA=3, CP0=4, LENGTH=3), CP0 index constants, Status/Cause bit positions, INIT_32.
- One sub-module: cp0_regs (Count/Compare/Status/Cause/EPC, priorities, irq). The GPR array and mux stay in wb_stage.

## Test plan
- Reset, then write reg 5 with ALU source alu_result=0x1234 and rs_addr=5 in the same cycle → rs_data=0x1234 (bypass); after the edge, still 0x1234. Write to reg 0 → reads 0.
- reg_src=MEM/IMM/RA with distinct inputs (0xA, 0xB, 0xC) → wb_data and stored reg match each. Invalid code 7 → wb_data 0.
- mtc0 Compare=10, Status=0x8001 → IP7 set at the expected cycle, irq=1. mtc0 Compare=20 → IP7=0, irq=0.
- exc_req (code 8, pc 0x400) simultaneous with mtc0 EPC=0x999 → EPC=0x400, ExcCode=8, EXL=1, irq masked. eret → EXL=0.
- mtc0 Count=0xFFFFFFFE → next reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- Assert rst mid-run with Status and regs nonzero → all zero immediately, irq=0, before the next clock edge.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: source-select codes, CP0 register map and field layout.
package wb_stage_pkg;

    localparam int          REG_SRC_LENGTH = 3;
    localparam logic [2:0]  REG_SRC_ALU    = 3'd0;
    localparam logic [2:0]  REG_SRC_MEM    = 3'd1;
    localparam logic [2:0]  REG_SRC_IMM    = 3'd2;
    localparam logic [2:0]  REG_SRC_RA     = 3'd3;
    localparam logic [2:0]  REG_SRC_CP0    = 3'd4;

    localparam logic [4:0]  CP0_COUNT      = 5'd9;
    localparam logic [4:0]  CP0_COMPARE    = 5'd11;
    localparam logic [4:0]  CP0_STATUS     = 5'd12;
    localparam logic [4:0]  CP0_CAUSE      = 5'd13;
    localparam logic [4:0]  CP0_EPC        = 5'd14;

    localparam int          STATUS_IE      = 0;
    localparam int          STATUS_EXL     = 1;
    localparam int          CAUSE_IP7      = 15;
    localparam int          CAUSE_EXC_LSB  = 2;
    localparam int          CAUSE_EXC_MSB  = 6;

    localparam logic [31:0] INIT_32        = 32'h0000_0000;
    // Implemented bits only; everything else reads back as zero.
    localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK    = 32'h0000_807C;

    typedef struct packed {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
    } cp0_wr_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register outputs consumed by write-back, plus the forwarded result.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic [31:0]               read_mem_data_in;
    logic [31:0]               alu_result_in;
    logic [31:0]               ext_imm_in;
    logic [31:0]               re_addr_in;
    logic [4:0]                dst_reg_in;
    logic                      reg_write_in;
    logic                      cp0_write_in;
    logic [REG_SRC_LENGTH-1:0] reg_src_in;
    logic [31:0]               wb_data;

    modport master (
        output read_mem_data_in, alu_result_in, ext_imm_in, re_addr_in,
        output dst_reg_in, reg_write_in, cp0_write_in, reg_src_in,
        input  wb_data
    );

    modport slave (
        input  read_mem_data_in, alu_result_in, ext_imm_in, re_addr_in,
        input  dst_reg_in, reg_write_in, cp0_write_in, reg_src_in,
        output wb_data
    );

endinterface

// File: rtl/wb_stage_cp0_regs.sv
// Minimal CP0: Count/Compare timer, Status, Cause, EPC with exception entry/return.
module cp0_regs
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  cp0_wr_t     wr,
    output logic [31:0] rd_data,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] epc,
    output logic        irq
);

    logic [31:0] count_q, compare_q, status_q, cause_q, epc_q;
    logic [31:0] status_d, cause_d, epc_d;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, timer_hit;

    assign wr_count   = wr.en && (wr.idx == CP0_COUNT);
    assign wr_compare = wr.en && (wr.idx == CP0_COMPARE);
    assign wr_status  = wr.en && (wr.idx == CP0_STATUS);
    assign wr_cause   = wr.en && (wr.idx == CP0_CAUSE);
    assign wr_epc     = wr.en && (wr.idx == CP0_EPC);
    assign timer_hit  = (count_q == compare_q) && (compare_q != INIT_32);

    // Exception entry wins over software writes to the exception-state registers.
    always_comb begin
        status_d = status_q;
        if (wr_status && !exc_req) status_d = wr.data & STATUS_WMASK;
        if (exc_req)   status_d[STATUS_EXL] = 1'b1;
        else if (eret) status_d[STATUS_EXL] = 1'b0;

        cause_d = cause_q;
        if (wr_cause && !exc_req) cause_d = wr.data & CAUSE_WMASK;
        if (exc_req) cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code;
        if (wr_compare)     cause_d[CAUSE_IP7] = 1'b0;
        else if (timer_hit) cause_d[CAUSE_IP7] = 1'b1;

        epc_d = epc_q;
        if (exc_req)     epc_d = exc_pc;
        else if (wr_epc) epc_d = wr.data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= INIT_32;
            compare_q <= INIT_32;
            status_q  <= INIT_32;
            cause_q   <= INIT_32;
            epc_q     <= INIT_32;
        end else begin
            count_q   <= wr_count ? wr.data : count_q + 32'd1;
            if (wr_compare) compare_q <= wr.data;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        case (wr.idx)
            CP0_COUNT:   rd_data = count_q;
            CP0_COMPARE: rd_data = compare_q;
            CP0_STATUS:  rd_data = status_q;
            CP0_CAUSE:   rd_data = cause_q;
            CP0_EPC:     rd_data = epc_q;
            default:     rd_data = INIT_32;
        endcase
    end

    assign epc = epc_q;
    assign irq = status_q[STATUS_IE] & ~status_q[STATUS_EXL] & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, GPR file with write-through read ports, and CP0.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   mw,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] epc,
    output logic        irq
);

    logic [31:0] gpr [0:31];
    logic [31:0] wb_data, cp0_rd;
    logic        gpr_we;
    cp0_wr_t     cp0_wr;

    // mtc0 and mfc0 share the rd field of the instruction, carried in ext_imm.
    assign cp0_wr = '{en: mw.cp0_write_in, idx: mw.ext_imm_in[15:11], data: mw.alu_result_in};

    cp0_regs u_cp0 (
        .clk      (clk),
        .rst      (rst),
        .wr       (cp0_wr),
        .rd_data  (cp0_rd),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .exc_pc   (exc_pc),
        .eret     (eret),
        .epc      (epc),
        .irq      (irq)
    );

    always_comb begin
        case (mw.reg_src_in)
            REG_SRC_ALU: wb_data = mw.alu_result_in;
            REG_SRC_MEM: wb_data = mw.read_mem_data_in;
            REG_SRC_IMM: wb_data = mw.ext_imm_in;
            REG_SRC_RA:  wb_data = mw.re_addr_in;
            REG_SRC_CP0: wb_data = cp0_rd;
            default:     wb_data = INIT_32;
        endcase
    end

    assign mw.wb_data = wb_data;
    assign gpr_we     = mw.reg_write_in && (mw.dst_reg_in != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) gpr[i] <= INIT_32;
        end else if (gpr_we) begin
            gpr[mw.dst_reg_in] <= wb_data;
        end
    end

    // Same-cycle write is bypassed so ID never needs a WB->ID forwarding path.
    assign rs_data = (rs_addr == 5'd0) ? INIT_32 :
                     (gpr_we && mw.dst_reg_in == rs_addr) ? wb_data : gpr[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? INIT_32 :
                     (gpr_we && mw.dst_reg_in == rt_addr) ? wb_data : gpr[rt_addr];

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized checks of wb_stage against a cycle-level architectural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, exc_code;
    logic [31:0] rs_data, rt_data, exc_pc, epc;
    logic        exc_req, eret, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage_if mw();

    wb_stage dut (
        .clk      (clk),
        .rst      (rst),
        .mw       (mw),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .exc_pc   (exc_pc),
        .eret     (eret),
        .epc      (epc),
        .irq      (irq)
    );

    // Architectural model
    logic [31:0] m_gpr [32];
    logic [31:0] m_count, m_compare, m_status, m_epc;
    logic        m_ip7;
    logic [4:0]  m_exc;

    function automatic logic [31:0] m_cp0(input logic [4:0] idx);
        case (idx)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {16'h0, m_ip7, 8'h0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wb();
        case (mw.reg_src_in)
            3'd0:    return mw.alu_result_in;
            3'd1:    return mw.read_mem_data_in;
            3'd2:    return mw.ext_imm_in;
            3'd3:    return mw.re_addr_in;
            3'd4:    return m_cp0(mw.ext_imm_in[15:11]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (mw.reg_write_in && mw.dst_reg_in == a) return m_wb();
        return m_gpr[a];
    endfunction

    function automatic logic m_irq();
        return m_status[0] & ~m_status[1] & m_ip7 & m_status[15];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_count = 0; m_compare = 0; m_status = 0; m_epc = 0; m_ip7 = 0; m_exc = 0;
    endfunction

    function automatic void model_edge();
        logic [31:0] wd;
        logic [31:0] d;
        logic [4:0]  idx;
        logic        mt, hit;
        wd  = m_wb();
        idx = mw.ext_imm_in[15:11];
        mt  = mw.cp0_write_in;
        d   = mw.alu_result_in;
        hit = (m_count == m_compare) && (m_compare != 0);
        if (mw.reg_write_in && mw.dst_reg_in != 0) m_gpr[mw.dst_reg_in] = wd;
        m_count = (mt && idx == 9) ? d : m_count + 1;
        if (mt && idx == 11) m_ip7 = 1'b0;
        else if (hit) m_ip7 = 1'b1;
        else if (mt && idx == 13 && !exc_req) m_ip7 = d[15];
        if (mt && idx == 11) m_compare = d;
        if (mt && idx == 12 && !exc_req) m_status = d & 32'h0000_FF03;
        if (exc_req) m_status[1] = 1'b1;
        else if (eret) m_status[1] = 1'b0;
        if (exc_req) m_exc = exc_code;
        else if (mt && idx == 13) m_exc = d[6:2];
        if (exc_req) m_epc = exc_pc;
        else if (mt && idx == 14) m_epc = d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("wb_data", mw.wb_data, m_wb());
        chk("rs_data", rs_data, m_read(rs_addr));
        chk("rt_data", rt_data, m_read(rt_addr));
        chk("irq", {31'h0, irq}, {31'h0, m_irq()});
        chk("epc", epc, m_epc);
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        mw.read_mem_data_in = 0; mw.alu_result_in = 0; mw.ext_imm_in = 0; mw.re_addr_in = 0;
        mw.dst_reg_in = 0; mw.reg_write_in = 0; mw.cp0_write_in = 0; mw.reg_src_in = 0;
        rs_addr = 0; rt_addr = 0; exc_req = 0; exc_code = 0; exc_pc = 0; eret = 0;
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
        idle();
        mw.cp0_write_in  = 1'b1;
        mw.ext_imm_in    = {16'h0, idx, 11'h0};
        mw.alu_result_in = val;
    endtask

    task automatic mfc0(input logic [4:0] idx);
        idle();
        mw.reg_src_in = 3'd4;
        mw.ext_imm_in = {16'h0, idx, 11'h0};
    endtask

    task automatic random_inputs();
        logic [4:0] idx;
        logic [4:0] pick [6];
        pick = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        idx = pick[$urandom_range(0, 5)];
        if (idx == 5'd0) idx = 5'($urandom);
        mw.read_mem_data_in = $urandom;
        mw.re_addr_in       = $urandom;
        mw.ext_imm_in       = {$urandom_range(0, 65535), idx, 11'($urandom)};
        mw.alu_result_in    = $urandom;
        mw.reg_src_in       = 3'($urandom_range(0, 7));
        mw.dst_reg_in       = 5'($urandom);
        mw.reg_write_in     = $urandom_range(0, 1) == 1;
        mw.cp0_write_in     = $urandom_range(0, 3) == 0;
        if (idx == 5'd11) mw.alu_result_in = m_count + $urandom_range(1, 6);
        if (idx == 5'd12 && $urandom_range(0, 1) == 1) mw.alu_result_in |= 32'h8001;
        rs_addr  = 5'($urandom);
        rt_addr  = $urandom_range(0, 1) == 1 ? mw.dst_reg_in : 5'($urandom);
        exc_req  = $urandom_range(0, 15) == 0;
        exc_code = 5'($urandom);
        exc_pc   = $urandom;
        eret     = $urandom_range(0, 15) == 0;
    endtask

    logic [31:0] src_vals [3];

    initial begin
        src_vals = '{32'hA, 32'hB, 32'hC};
        model_reset();
        idle();
        rst = 1'b0;
        rs_addr = 5'd5;
        #1;
        check_outputs();
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        rst = 1'b1;

        // GPR write with same-cycle bypass
        idle();
        mw.reg_write_in = 1; mw.dst_reg_in = 5; mw.alu_result_in = 32'h1234; rs_addr = 5;
        #1 chk("bypass", rs_data, 32'h1234);
        tick();
        idle(); rs_addr = 5;
        #1 chk("stored", rs_data, 32'h1234);
        tick();
        idle(); mw.reg_write_in = 1; mw.dst_reg_in = 0; mw.alu_result_in = 32'h55;
        #1 chk("r0_bypass", rt_data, 32'h0);
        tick();
        idle();
        #1 chk("r0_read", rt_data, 32'h0);
        tick();

        // MEM/IMM/RA sources into r6..r8
        for (int k = 0; k < 3; k++) begin
            idle();
            mw.read_mem_data_in = 32'hA; mw.ext_imm_in = 32'hB; mw.re_addr_in = 32'hC;
            mw.alu_result_in = 32'hF; mw.reg_src_in = 3'(k + 1);
            mw.reg_write_in = 1; mw.dst_reg_in = 5'(6 + k);
            #1 chk("src_sel", mw.wb_data, src_vals[k]);
            tick();
        end
        idle(); rs_addr = 6; rt_addr = 7;
        #1 chk("r6", rs_data, 32'hA);
        chk("r7", rt_data, 32'hB);
        tick();
        idle(); rs_addr = 8;
        mw.reg_src_in = 3'd7; mw.alu_result_in = 32'h77; mw.read_mem_data_in = 32'h66;
        #1 chk("r8", rs_data, 32'hC);
        chk("bad_src", mw.wb_data, 32'h0);
        tick();

        // Timer interrupt
        mtc0(5'd12, 32'h8001); tick();
        mtc0(5'd11, 32'd10);   tick();
        mtc0(5'd9,  32'd5);    tick();
        idle();
        repeat (5) tick();
        #1 chk("irq_pre", {31'h0, irq}, 32'h0);
        tick();
        mfc0(5'd13);
        #1 chk("irq_timer", {31'h0, irq}, 32'h1);
        chk("ip7_set", {31'h0, mw.wb_data[15]}, 32'h1);
        tick();
        mtc0(5'd11, 32'd20); tick();
        idle();
        #1 chk("irq_clr", {31'h0, irq}, 32'h0);
        tick();

        // Exception entry beats mtc0 EPC, then eret
        mtc0(5'd14, 32'h999);
        exc_req = 1; exc_code = 5'd8; exc_pc = 32'h400;
        tick();
        mfc0(5'd13);
        #1 chk("exc_epc", epc, 32'h400);
        chk("exc_code", {27'h0, mw.wb_data[6:2]}, 32'd8);
        chk("exc_irq", {31'h0, irq}, 32'h0);
        tick();
        mfc0(5'd12);
        #1 chk("exl_set", {31'h0, mw.wb_data[1]}, 32'h1);
        tick();
        idle(); eret = 1; tick();
        mfc0(5'd12);
        #1 chk("exl_clr", {31'h0, mw.wb_data[1]}, 32'h0);
        tick();

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFE); tick();
        mfc0(5'd9);
        #1 chk("cnt_fe", mw.wb_data, 32'hFFFF_FFFE);
        tick();
        #1 chk("cnt_ff", mw.wb_data, 32'hFFFF_FFFF);
        tick();
        #1 chk("cnt_00", mw.wb_data, 32'h0);
        tick();

        // Asynchronous reset mid-cycle
        mtc0(5'd12, 32'h8001); tick();
        idle(); rs_addr = 5;
        #2 rst = 1'b0;
        model_reset();
        #1 chk("rst_rs", rs_data, 32'h0);
        chk("rst_irq2", {31'h0, irq}, 32'h0);
        chk("rst_epc2", epc, 32'h0);
        check_outputs();
        #2 rst = 1'b1;
        tick();

        repeat (400) begin
            random_inputs();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
